// File: rtl/mmio_uart_tx_if.sv
// Data-memory port bundle between the core's M stage and the UART transmitter.
interface mmio_uart_tx_if;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic        sel;

    modport master (output memwriteM, aluoutM, writedataM, input readdataM, sel);
    modport slave  (input memwriteM, aluoutM, writedataM, output readdataM, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 transmitter: 16-byte register window, small TX FIFO, serial shifter.
//
// state   | meaning
// S_IDLE  | line high, waiting for enable and a queued byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (high); may chain straight into the next START
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_uart_tx_if.slave  bus,
    output logic           txd,
    output logic           tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_txd;
    logic            r_busy;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic            r_enable;

    logic            w_sel;
    logic [1:0]      w_off;
    logic            w_wr;
    logic            w_push_req;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_baud_end;
    logic [7:0]      w_head;
    logic [31:0]     w_rdata;
    logic            w_unused_ok;

    assign w_sel      = (bus.aluoutM[31:4] == BASE_ADDR[31:4]);
    assign w_off      = bus.aluoutM[3:2];
    assign w_wr       = bus.memwriteM && w_sel;
    assign w_push_req = w_wr && (w_off == 2'd0);
    assign w_full     = (r_level == LW'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_head     = r_mem[r_rptr];

    // Pops happen only from IDLE or at the last cycle of STOP, which is what
    // makes back-to-back frames contiguous.
    assign w_pop     = r_enable && !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
    assign w_push_ok = w_push_req && (!w_full || w_pop);

    assign w_unused_ok = ^{bus.writedataM[31:8], bus.aluoutM[1:0]};

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= bus.writedataM[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_enable   <= 1'b1;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PW'(1);
            if (w_pop)     r_rptr <= r_rptr + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
            if (w_wr && (w_off == 2'd2)) begin
                r_enable <= bus.writedataM[0];
                if (bus.writedataM[1]) r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= S_START;
                        r_baud  <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_state <= S_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_baud  <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            2'd1:    w_rdata = {24'd0, 4'(r_level), r_overflow, r_busy, w_empty, w_full};
            2'd2:    w_rdata = {31'd0, r_enable};
            default: w_rdata = '0;
        endcase
    end

    assign bus.sel       = w_sel;
    assign bus.readdataM = w_sel ? w_rdata : 32'd0;
    assign txd           = r_txd;
    assign tx_busy       = r_busy;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register reads checked directly, serial frames decoded
// by a line monitor and matched against a queue of expected bytes.
module tb_mmio_uart_tx;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset_n;
    logic txd;
    logic tx_busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .txd     (txd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Store completes on the posedge; returns 1ns after that edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.memwriteM  = 1'b1;
        bus.aluoutM    = addr;
        bus.writedataM = data;
        @(posedge clk);
        #1;
        bus.memwriteM  = 1'b0;
        bus.aluoutM    = 32'd0;
        bus.writedataM = 32'd0;
    endtask

    task automatic load(input string name, input logic [31:0] addr,
                        input logic [31:0] exp, input logic exp_sel);
        @(negedge clk);
        bus.aluoutM = addr;
        #1;
        check({name, "_data"}, bus.readdataM, exp);
        check({name, "_sel"}, {31'd0, bus.sel}, {31'd0, exp_sel});
        bus.aluoutM = 32'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy !== 1'b0 && n < budget);
        check(name, {31'd0, tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Line monitor: decode one frame from its first low sample, mid-bit sampling.
    task automatic rx_frame();
        logic [9:0] bits = '0;
        logic [7:0] exp;
        for (int j = 1; j < 10 * CPB; j++) begin
            @(negedge clk);
            if (reset_n !== 1'b1) return;
            if (j % CPB == CPB / 2) bits[j / CPB] = txd;
        end
        check("frame_start_stop", {30'd0, bits[9], bits[0]}, 32'd2);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got byte 0x%02h expected no frame", bits[8:1]);
        end else begin
            exp = exp_q.pop_front();
            if (bits[8:1] !== exp) begin
                errors++;
                $display("FAIL frame_byte: got 0x%02h expected 0x%02h", bits[8:1], exp);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0) rx_frame();
        end
    end

    initial begin
        logic [7:0] b;
        logic       exp_txd;
        int         cnt;
        bit         seen;

        bus.memwriteM  = 1'b0;
        bus.aluoutM    = 32'd0;
        bus.writedataM = 32'd0;
        reset_n        = 1'b1;

        // 1: async reset without a clock edge
        #2 reset_n = 1'b0;
        #1;
        check("t1_txd", {31'd0, txd}, 32'd1);
        check("t1_busy", {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load("t1_status", BASE + 32'h4, 32'h0000_0002, 1'b1);
        load("t1_ctrl", BASE + 32'h8, 32'h0000_0001, 1'b1);
        load("t1_txdata", BASE, 32'h0, 1'b1);

        // 2: single byte, cycle-exact waveform after the store edge
        b = 8'hA5;
        exp_q.push_back(b);
        store(BASE, 32'h0000_00A5);
        for (int n = 0; n <= 44; n++) begin
            @(negedge clk);
            if (n == 0)       exp_txd = 1'b1;
            else if (n <= 4)  exp_txd = 1'b0;
            else if (n <= 36) exp_txd = b[(n - 5) / 4];
            else              exp_txd = 1'b1;
            check($sformatf("t2_txd_c%0d", n), {31'd0, txd}, {31'd0, exp_txd});
            check($sformatf("t2_busy_c%0d", n), {31'd0, tx_busy},
                  {31'd0, (n >= 1 && n <= 40)});
        end
        load("t2_status", BASE + 32'h4, 32'h0000_0002, 1'b1);

        // 3: overflow with transmitter disabled, then four contiguous frames
        store(BASE + 32'h8, 32'h0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        store(BASE, 32'h44);
        store(BASE, 32'h55);
        load("t3_status_ovf", BASE + 32'h4, 32'h0000_0049, 1'b1);
        load("t3_ctrl_off", BASE + 32'h8, 32'h0000_0000, 1'b1);
        store(BASE + 32'h8, 32'h3);
        cnt  = 0;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("t3_busy_cycles", cnt, 160);
        repeat (4) @(negedge clk);
        load("t3_status_end", BASE + 32'h4, 32'h0000_0002, 1'b1);

        // 4: push lands on the same edge as the first pop of a full FIFO
        store(BASE + 32'h8, 32'h0);
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h72);
        exp_q.push_back(8'h73);
        exp_q.push_back(8'h74);
        exp_q.push_back(8'h66);
        store(BASE, 32'h71);
        store(BASE, 32'h72);
        store(BASE, 32'h73);
        store(BASE, 32'h74);
        load("t4_status_full", BASE + 32'h4, 32'h0000_0041, 1'b1);
        store(BASE + 32'h8, 32'h1);
        store(BASE, 32'h66);
        load("t4_status_collide", BASE + 32'h4, 32'h0000_0045, 1'b1);
        wait_idle("t4_idle_timeout", 400);
        load("t4_status_end", BASE + 32'h4, 32'h0000_0002, 1'b1);

        // 5: accesses outside the window
        store(32'h0000_0040, 32'hFF);
        load("t5_outside", 32'h0000_0044, 32'h0, 1'b0);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tx_busy !== 1'b0) cnt++;
        end
        check("t5_no_frame", cnt, 0);
        load("t5_status", BASE + 32'h4, 32'h0000_0002, 1'b1);

        // 6: reset during data bit 3 of 0x52 (bit 3 is low)
        exp_q.push_back(8'h52);
        store(BASE, 32'h52);
        repeat (18) @(negedge clk);
        check("t6_bit3_low", {31'd0, txd}, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_txd", {31'd0, txd}, 32'd1);
        check("t6_busy", {31'd0, tx_busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load("t6_status", BASE + 32'h4, 32'h0000_0002, 1'b1);
        load("t6_ctrl", BASE + 32'h8, 32'h0000_0001, 1'b1);
        cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || txd !== 1'b1) cnt++;
        end
        check("t6_no_residual", cnt, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
